// File: rtl/adv7513_cfg_pkg.sv
// Shared types and the ADV7513 power-up register table for the configuration sequencer.
package adv7513_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE_S     = 3'd0,
    WAIT_HPD_S = 3'd1,
    PWR_WAIT_S = 3'd2,
    ISSUE_S    = 3'd3,
    RESP_S     = 3'd4,
    DONE_S     = 3'd5,
    ERR_S      = 3'd6
  } cfg_fsm_t;

  typedef struct packed {
    logic [7:0] reg_addr;
    logic [7:0] data;
  } cfg_entry_t;

  localparam int unsigned NUM_ENTRIES = 14;

  function automatic cfg_entry_t cfg_table(input logic [4:0] idx);
    cfg_entry_t e;
    case (idx)
      5'd0:    e = '{reg_addr: 8'h41, data: 8'h10};
      5'd1:    e = '{reg_addr: 8'h98, data: 8'h03};
      5'd2:    e = '{reg_addr: 8'h9A, data: 8'hE0};
      5'd3:    e = '{reg_addr: 8'h9C, data: 8'h30};
      5'd4:    e = '{reg_addr: 8'h9D, data: 8'h61};
      5'd5:    e = '{reg_addr: 8'hA2, data: 8'hA4};
      5'd6:    e = '{reg_addr: 8'hA3, data: 8'hA4};
      5'd7:    e = '{reg_addr: 8'hE0, data: 8'hD0};
      5'd8:    e = '{reg_addr: 8'hF9, data: 8'h00};
      5'd9:    e = '{reg_addr: 8'h15, data: 8'h00};
      5'd10:   e = '{reg_addr: 8'h16, data: 8'h30};
      5'd11:   e = '{reg_addr: 8'h17, data: 8'h02};
      5'd12:   e = '{reg_addr: 8'hAF, data: 8'h06};
      5'd13:   e = '{reg_addr: 8'hD6, data: 8'hC0};
      default: e = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/adv7513_cfg_rom.sv
// Register-table lookup; swap this module to substitute a per-board table.
module adv7513_cfg_rom
  import adv7513_cfg_pkg::*;
(
  input  logic [4:0] idx,
  output cfg_entry_t entry
);

  always_comb entry = cfg_table(idx);

endmodule

// File: rtl/adv7513_cfg_seq.sv
// ADV7513 power-up / hot-plug configuration sequencer: waits for HPD, settles,
// writes the register table over the shared I2C master, then enables the video driver.
module adv7513_cfg_seq
  import adv7513_cfg_pkg::*;
#(
  parameter logic [7:0]  I2C_DEV_ADDR   = 8'h72,
  parameter int unsigned PWRUP_WAIT_CYC = 14_850_000,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_start,
  input  logic       hpd,
  output logic       i2c_req_valid,
  input  logic       i2c_req_ready,
  output logic [7:0] i2c_dev_addr,
  output logic [7:0] i2c_reg_addr,
  output logic [7:0] i2c_wdata,
  input  logic       i2c_done,
  input  logic       i2c_nack,
  output logic       drvr_en,
  output logic       cfg_busy,
  output logic       cfg_err,
  output logic [4:0] cfg_idx
);

  localparam int unsigned CNT_W   = $clog2(PWRUP_WAIT_CYC + 1);
  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [4:0]         LAST_IDX  = 5'(NUM_ENTRIES - 1);
  localparam logic [CNT_W-1:0]   WAIT_LOAD = CNT_W'(PWRUP_WAIT_CYC - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);

  cfg_fsm_t           state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [RETRY_W-1:0] retry, retry_nxt;
  logic [4:0]         idx, idx_nxt;
  logic               abort, abort_nxt;
  logic               err_nxt;
  cfg_entry_t         entry;

  // Looked up on the next index so the registered request fields line up with the state.
  adv7513_cfg_rom u_rom (
    .idx   (idx_nxt),
    .entry (entry)
  );

  assign i2c_dev_addr = I2C_DEV_ADDR;
  assign cfg_idx      = idx;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    retry_nxt = retry;
    idx_nxt   = idx;
    abort_nxt = abort;
    err_nxt   = cfg_err;
    case (state)
      IDLE_S: begin
        if (cfg_start) begin
          state_nxt = WAIT_HPD_S;
          idx_nxt   = '0;
          retry_nxt = '0;
        end
      end
      WAIT_HPD_S: begin
        if (hpd) begin
          state_nxt = PWR_WAIT_S;
          cnt_nxt   = WAIT_LOAD;
        end
      end
      PWR_WAIT_S: begin
        if (!hpd)            state_nxt = WAIT_HPD_S;
        else if (cnt == '0)  state_nxt = ISSUE_S;
        else                 cnt_nxt   = cnt - CNT_W'(1);
      end
      ISSUE_S: begin
        // An unplug cannot withdraw a presented request; remember it for RESP_S.
        if (!hpd) abort_nxt = 1'b1;
        if (i2c_req_ready) state_nxt = RESP_S;
      end
      RESP_S: begin
        if (i2c_done) begin
          if (abort || !hpd) begin
            state_nxt = WAIT_HPD_S;
            idx_nxt   = '0;
            retry_nxt = '0;
            abort_nxt = 1'b0;
          end else if (!i2c_nack) begin
            if (idx == LAST_IDX) begin
              state_nxt = DONE_S;
            end else begin
              state_nxt = ISSUE_S;
              idx_nxt   = idx + 5'd1;
              retry_nxt = '0;
            end
          end else if (retry == RETRY_LIM) begin
            state_nxt = ERR_S;
            err_nxt   = 1'b1;
          end else begin
            state_nxt = ISSUE_S;
            retry_nxt = retry + RETRY_W'(1);
          end
        end else if (!hpd) begin
          abort_nxt = 1'b1;
        end
      end
      DONE_S: begin
        if (!hpd) begin
          state_nxt = WAIT_HPD_S;
          idx_nxt   = '0;
          retry_nxt = '0;
        end
      end
      ERR_S: begin
        if (cfg_start) begin
          state_nxt = WAIT_HPD_S;
          idx_nxt   = '0;
          retry_nxt = '0;
          err_nxt   = 1'b0;
        end
      end
      default: state_nxt = IDLE_S;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE_S;
      cnt           <= '0;
      retry         <= '0;
      idx           <= '0;
      abort         <= 1'b0;
      i2c_req_valid <= 1'b0;
      i2c_reg_addr  <= '0;
      i2c_wdata     <= '0;
      drvr_en       <= 1'b0;
      cfg_busy      <= 1'b0;
      cfg_err       <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      retry         <= retry_nxt;
      idx           <= idx_nxt;
      abort         <= abort_nxt;
      i2c_req_valid <= (state_nxt == ISSUE_S);
      if (state_nxt == ISSUE_S) begin
        i2c_reg_addr <= entry.reg_addr;
        i2c_wdata    <= entry.data;
      end
      drvr_en       <= (state_nxt == DONE_S);
      cfg_busy      <= !(state_nxt inside {IDLE_S, DONE_S, ERR_S});
      cfg_err       <= err_nxt;
    end
  end

endmodule

// File: tb/tb_adv7513_cfg_seq.sv
// Randomized bench for adv7513_cfg_seq: an I2C responder with per-entry NACK plans,
// checked against an attempt-list model built from the register table.
`timescale 1ns/1ps
module tb_adv7513_cfg_seq;

  localparam int unsigned P    = 10;
  localparam int unsigned MAXR = 3;
  localparam int unsigned N    = 14;

  logic       clk = 1'b0;
  logic       rst_n, cfg_start, hpd;
  logic       i2c_req_valid, i2c_req_ready, i2c_done, i2c_nack;
  logic [7:0] i2c_dev_addr, i2c_reg_addr, i2c_wdata;
  logic       drvr_en, cfg_busy, cfg_err;
  logic [4:0] cfg_idx;

  always #5 clk = ~clk;

  adv7513_cfg_seq #(
    .I2C_DEV_ADDR   (8'h72),
    .PWRUP_WAIT_CYC (P),
    .MAX_RETRY      (MAXR)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_start     (cfg_start),
    .hpd           (hpd),
    .i2c_req_valid (i2c_req_valid),
    .i2c_req_ready (i2c_req_ready),
    .i2c_dev_addr  (i2c_dev_addr),
    .i2c_reg_addr  (i2c_reg_addr),
    .i2c_wdata     (i2c_wdata),
    .i2c_done      (i2c_done),
    .i2c_nack      (i2c_nack),
    .drvr_en       (drvr_en),
    .cfg_busy      (cfg_busy),
    .cfg_err       (cfg_err),
    .cfg_idx       (cfg_idx)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [7:0] tbl_reg [N] = '{8'h41, 8'h98, 8'h9A, 8'h9C, 8'h9D, 8'hA2, 8'hA3,
                              8'hE0, 8'hF9, 8'h15, 8'h16, 8'h17, 8'hAF, 8'hD6};
  logic [7:0] tbl_dat [N] = '{8'h10, 8'h03, 8'hE0, 8'h30, 8'h61, 8'hA4, 8'hA4,
                              8'hD0, 8'h00, 8'h00, 8'h30, 8'h02, 8'h06, 8'hC0};

  // Responder configuration and observed request log
  int         nack_plan [N];
  int         attempts  [N];
  int         lat_min = 5, lat_max = 5, stall_max = 0, stall_fix = 0;
  int         slow_entry = -1, slow_lat = 0;
  int         n_done = 0;
  int         exp_mode = 0;  // 0 idle, 1 done, 2 error
  logic [7:0] log_reg [$];
  logic [7:0] log_dat [$];

  function automatic int find_entry(input logic [7:0] ra);
    for (int i = 0; i < N; i++) if (tbl_reg[i] == ra) return i;
    return -1;
  endfunction

  task automatic clear_model();
    log_reg.delete();
    log_dat.delete();
    for (int i = 0; i < N; i++) attempts[i] = 0;
  endtask

  task automatic clear_plan();
    for (int i = 0; i < N; i++) nack_plan[i] = 0;
  endtask

  // I2C master model: acts 1 ns after each falling edge
  initial begin
    int         e, countdown, stall;
    bit         outstanding, holding, cur_nack;
    logic [7:0] hold_reg, hold_dat;
    i2c_req_ready = 1'b0;
    i2c_done      = 1'b0;
    i2c_nack      = 1'b0;
    outstanding   = 0;
    holding       = 0;
    countdown     = 0;
    stall         = 0;
    cur_nack      = 0;
    forever begin
      @(negedge clk);
      #1;
      i2c_done = 1'b0;
      i2c_nack = 1'b0;
      if (!rst_n) begin
        i2c_req_ready = 1'b0;
        outstanding   = 0;
        holding       = 0;
      end else if (i2c_req_ready) begin
        i2c_req_ready = 1'b0;
        check_eq("valid_drop", i2c_req_valid, 0);
        log_reg.push_back(hold_reg);
        log_dat.push_back(hold_dat);
        e = find_entry(hold_reg);
        cur_nack = 0;
        if (e >= 0) begin
          cur_nack = (attempts[e] < nack_plan[e]);
          attempts[e]++;
        end
        countdown   = (e == slow_entry) ? slow_lat : int'($urandom_range(lat_max, lat_min));
        outstanding = 1;
        holding     = 0;
      end else if (outstanding) begin
        countdown--;
        if (countdown <= 0) begin
          i2c_done    = 1'b1;
          i2c_nack    = cur_nack;
          outstanding = 0;
          n_done++;
        end
      end else if (i2c_req_valid) begin
        if (!holding) begin
          holding  = 1;
          hold_reg = i2c_reg_addr;
          hold_dat = i2c_wdata;
          stall    = (stall_fix > 0) ? stall_fix : int'($urandom_range(stall_max, 0));
        end else begin
          check_eq("stable_reg", i2c_reg_addr, hold_reg);
          check_eq("stable_dat", i2c_wdata, hold_dat);
        end
        if (stall == 0) i2c_req_ready = 1'b1;
        else            stall--;
      end
    end
  end

  // Expected request list: each entry retried until ACK, at most MAXR+1 attempts
  task automatic check_log(input string tag, output bit err_exp);
    int exp_q [$];
    int att;
    err_exp = 0;
    for (int e = 0; e < N && !err_exp; e++) begin
      att = (nack_plan[e] > MAXR) ? MAXR + 1 : nack_plan[e] + 1;
      for (int a = 0; a < att; a++) exp_q.push_back(e);
      if (nack_plan[e] > MAXR) err_exp = 1;
    end
    check_eq({tag, "_len"}, log_reg.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_reg.size(); i++) begin
      check_eq({tag, "_reg"}, log_reg[i], tbl_reg[exp_q[i]]);
      check_eq({tag, "_dat"}, log_dat[i], tbl_dat[exp_q[i]]);
    end
  endtask

  // Called on a falling edge that counts as n0 after the trigger was driven
  task automatic finish_run(input string tag, input int n0, input int exp_lat);
    bit ok, err_exp;
    int first_v, vc;
    ok = 0;
    first_v = 0;
    for (int n = n0; n < 4000; n++) begin
      if (i2c_req_valid && first_v == 0) first_v = n;
      if (drvr_en || cfg_err) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    check_eq({tag, "_finished"}, ok, 1);
    if (exp_lat > 0) check_eq({tag, "_first_req_lat"}, first_v, exp_lat);
    check_log(tag, err_exp);
    check_eq({tag, "_drvr_en"}, drvr_en, !err_exp);
    check_eq({tag, "_cfg_err"}, cfg_err, err_exp);
    check_eq({tag, "_busy"}, cfg_busy, 0);
    if (err_exp) begin
      vc = 0;
      repeat (20) begin
        @(negedge clk);
        if (i2c_req_valid) vc++;
      end
      check_eq({tag, "_quiet_in_err"}, vc, 0);
    end
    exp_mode = err_exp ? 2 : 1;
  endtask

  // cfg_start path: start sampled next edge, one edge to see hpd, then P wait cycles
  // hpd path: hpd sampled next edge, then P wait cycles
  task automatic run_seq(input string tag);
    clear_model();
    if (exp_mode == 1) begin
      hpd = 1'b0;
      @(negedge clk);
      check_eq({tag, "_unplug_drvr"}, drvr_en, 0);
      check_eq({tag, "_unplug_busy"}, cfg_busy, 1);
      check_eq({tag, "_unplug_idx"}, cfg_idx, 0);
      repeat (3) @(negedge clk);
      hpd = 1'b1;
      @(negedge clk);
      finish_run(tag, 1, P + 1);
    end else begin
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
      check_eq({tag, "_start_busy"}, cfg_busy, 1);
      check_eq({tag, "_start_err_clr"}, cfg_err, 0);
      finish_run(tag, 1, P + 2);
    end
  endtask

  initial begin
    int  d0, vc, r;
    bit  got;
    rst_n     = 1'b0;
    cfg_start = 1'b0;
    hpd       = 1'b0;
    clear_plan();
    repeat (3) @(negedge clk);
    check_eq("rst_valid", i2c_req_valid, 0);
    check_eq("rst_reg", i2c_reg_addr, 0);
    check_eq("rst_dat", i2c_wdata, 0);
    check_eq("rst_drvr", drvr_en, 0);
    check_eq("rst_busy", cfg_busy, 0);
    check_eq("rst_err", cfg_err, 0);
    check_eq("rst_idx", cfg_idx, 0);
    check_eq("dev_addr", i2c_dev_addr, 8'h72);
    rst_n = 1'b1;
    hpd   = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("idle_ignores_hpd", {cfg_busy, i2c_req_valid}, 0);

    run_seq("basic");

    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    check_eq("done_ignores_start", {drvr_en, cfg_busy}, 2'b10);

    clear_plan();
    nack_plan[3] = 2;
    run_seq("nack3");

    clear_plan();
    nack_plan[0] = 4;
    run_seq("err0");

    clear_plan();
    run_seq("err_restart");

    lat_min   = 1;
    lat_max   = 6;
    stall_max = 3;
    for (int it = 0; it < 8; it++) begin
      for (int e = 0; e < N; e++) begin
        r = int'($urandom_range(99, 0));
        nack_plan[e] = (r < 70) ? 0 : (r < 96) ? int'($urandom_range(3, 1)) : 4;
      end
      run_seq("rand");
    end

    // Reset in the middle of a sequence
    clear_plan();
    clear_model();
    if (exp_mode == 1) begin
      hpd = 1'b0;
      @(negedge clk);
      hpd = 1'b1;
    end else begin
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
    end
    got = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (log_reg.size() >= 3) begin
        got = 1;
        break;
      end
    end
    check_eq("midrst_progress", got, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("midrst_valid", i2c_req_valid, 0);
    check_eq("midrst_reg", i2c_reg_addr, 0);
    check_eq("midrst_dat", i2c_wdata, 0);
    check_eq("midrst_flags", {drvr_en, cfg_busy, cfg_err}, 0);
    check_eq("midrst_idx", cfg_idx, 0);
    rst_n = 1'b1;
    @(negedge clk);
    exp_mode = 0;

    // Unplug while waiting on the response to entry 7
    clear_plan();
    clear_model();
    slow_entry = 7;
    slow_lat   = 25;
    cfg_start  = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    got = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (log_reg.size() >= 8) begin
        got = 1;
        break;
      end
    end
    check_eq("unplug_reached_e7", got, 1);
    hpd = 1'b0;
    d0  = n_done;
    vc  = 0;
    got = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (n_done != d0) begin
        got = 1;
        break;
      end
      if (i2c_req_valid) vc++;
    end
    check_eq("unplug_done_seen", got, 1);
    check_eq("unplug_no_req", vc, 0);
    check_eq("unplug_idx", cfg_idx, 0);
    check_eq("unplug_busy", cfg_busy, 1);
    check_eq("unplug_out", {i2c_req_valid, drvr_en}, 0);
    vc = 0;
    repeat (10) begin
      @(negedge clk);
      if (i2c_req_valid) vc++;
    end
    check_eq("unplug_wait_quiet", vc, 0);
    slow_entry = -1;
    clear_model();
    hpd = 1'b1;
    @(negedge clk);
    finish_run("replug", 1, P + 1);

    // Long ready stall: request fields must hold steady
    stall_fix = 20;
    lat_min   = 2;
    lat_max   = 2;
    run_seq("stall");
    stall_fix = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
